// File: rtl/axi_wr_resp_gen.sv
// AXI4 slave-side write-response generator.
// Keeps accepted AW bursts in a small circular queue, counts W beats against
// AWLEN, flags out-of-range or malformed bursts, and returns one B per burst
// in AW order.
module axi_wr_resp_gen #(
  parameter int ID_W      = 1,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 4,
  parameter int MEM_BYTES = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ID_W-1:0]          s_awid,
  input  logic [ADDR_W-1:0]        s_awaddr,
  input  logic [7:0]               s_awlen,
  input  logic                     s_awvalid,
  output logic                     s_awready,
  input  logic                     s_wlast,
  input  logic                     s_wvalid,
  output logic                     s_wready,
  output logic                     wr_beat,
  output logic [ID_W-1:0]          s_bid,
  output logic [1:0]               s_bresp,
  output logic                     s_bvalid,
  input  logic                     s_bready,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] MEM_LIM = ADDR_W'(MEM_BYTES);

  typedef logic [PW:0] ptr_t;

  // Three pointers with an extra wrap bit: push, burst receiving data, oldest done.
  ptr_t aw_ptr_q, aw_ptr_d;
  ptr_t w_ptr_q,  w_ptr_d;
  ptr_t b_ptr_q,  b_ptr_d;
  logic [7:0] cnt_q, cnt_d;
  // Holds AW ready low until the first edge after reset release.
  logic rdy_q, rdy_d;

  logic [DEPTH-1:0][ID_W-1:0] id_q,  id_d;
  logic [DEPTH-1:0]           err_q, err_d;
  logic [DEPTH-1:0][7:0]      len_q, len_d;

  logic [PW-1:0] aw_idx, w_idx, b_idx;
  logic          full, aw_hs, b_hs;

  assign aw_idx = aw_ptr_q[PW-1:0];
  assign w_idx  = w_ptr_q[PW-1:0];
  assign b_idx  = b_ptr_q[PW-1:0];

  // Handshake qualifiers and outputs, all derived from registered state.
  always_comb begin
    full        = (aw_ptr_q[PW] != b_ptr_q[PW]) && (aw_idx == b_idx);
    outstanding = aw_ptr_q - b_ptr_q;
    s_awready   = rdy_q && !full;
    s_wready    = (w_ptr_q != aw_ptr_q);
    s_bvalid    = (b_ptr_q != w_ptr_q);
    wr_beat     = s_wvalid && s_wready;
    aw_hs       = s_awvalid && s_awready;
    b_hs        = s_bvalid && s_bready;
    s_bid       = s_bvalid ? id_q[b_idx] : '0;
    s_bresp     = (s_bvalid && err_q[b_idx]) ? 2'b10 : 2'b00;
  end

  // Next-state: AW push, W beat accounting / burst close, B pop.
  always_comb begin
    aw_ptr_d = aw_ptr_q;
    w_ptr_d  = w_ptr_q;
    b_ptr_d  = b_ptr_q;
    cnt_d    = cnt_q;
    rdy_d    = 1'b1;
    id_d     = id_q;
    err_d    = err_q;
    len_d    = len_q;

    if (aw_hs) begin
      id_d[aw_idx]  = s_awid;
      err_d[aw_idx] = (s_awaddr >= MEM_LIM);
      len_d[aw_idx] = s_awlen;
      aw_ptr_d      = aw_ptr_q + ptr_t'(1);
    end

    // W only targets a burst between w_ptr and aw_ptr, never the AW slot.
    if (wr_beat) begin
      if (s_wlast) begin
        if (cnt_q != len_q[w_idx]) err_d[w_idx] = 1'b1;
        w_ptr_d = w_ptr_q + ptr_t'(1);
        cnt_d   = 8'd0;
      end else begin
        if (cnt_q == len_q[w_idx]) err_d[w_idx] = 1'b1;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
    end

    if (b_hs) b_ptr_d = b_ptr_q + ptr_t'(1);
  end

  // State registers; reset discards every pending burst and response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_ptr_q <= '0;
      w_ptr_q  <= '0;
      b_ptr_q  <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      id_q     <= '0;
      err_q    <= '0;
      len_q    <= '0;
    end else begin
      aw_ptr_q <= aw_ptr_d;
      w_ptr_q  <= w_ptr_d;
      b_ptr_q  <= b_ptr_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      id_q     <= id_d;
      err_q    <= err_d;
      len_q    <= len_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_resp_gen.sv
// Scoreboard bench for axi_wr_resp_gen: expected B responses are queued when a
// burst is issued and compared whenever the DUT presents B.
module tb_axi_wr_resp_gen;

  localparam int ID_W   = 1;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ID_W-1:0]   s_awid;
  logic [ADDR_W-1:0] s_awaddr;
  logic [7:0]        s_awlen;
  logic              s_awvalid, s_awready;
  logic              s_wlast, s_wvalid, s_wready, wr_beat;
  logic [ID_W-1:0]   s_bid;
  logic [1:0]        s_bresp;
  logic              s_bvalid, s_bready;
  logic [$clog2(DEPTH):0] outstanding;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_exp_t;

  b_exp_t sb_q[$];
  int n_chk = 0;
  int n_err = 0;
  int beats = 0;

  axi_wr_resp_gen #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MEM_BYTES(4096)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .wr_beat(wr_beat),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count accepted W beats.
  always @(posedge clk) if (reset_n && wr_beat) beats++;

  // B monitor: every presented response is checked against the scoreboard head,
  // including each cycle it is held under backpressure; pop on handshake.
  always @(negedge clk) begin
    if (reset_n && s_bvalid) begin
      if (sb_q.size() == 0) begin
        chk("b_unexpected", 32'(s_bvalid), 32'd0);
      end else begin
        chk("bid", 32'(s_bid), 32'(sb_q[0].id));
        chk("bresp", 32'(s_bresp), 32'(sb_q[0].resp));
        if (s_bready) void'(sb_q.pop_front());
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic do_aw(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit hs;
    int t;
    hs = 0; t = 0;
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awvalid = 1'b1;
    while (!hs && t < 50) begin
      @(negedge clk); hs = s_awready;
      @(posedge clk); #1; t++;
    end
    if (!hs) chk("aw_timeout", 32'd0, 32'd1);
    s_awvalid = 1'b0;
  endtask

  task automatic do_w(input int nbeats, input int last_at);
    for (int b = 1; b <= nbeats; b++) begin
      bit hs;
      int t;
      hs = 0; t = 0;
      s_wvalid = 1'b1; s_wlast = (b == last_at);
      while (!hs && t < 50) begin
        @(negedge clk); hs = s_wready;
        @(posedge clk); #1; t++;
      end
      if (!hs) chk("w_timeout", 32'd0, 32'd1);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk); t++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int b0;
    reset_n = 1'b0; s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awvalid = 1'b0;
    s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(s_awready), 32'd0);
    chk("rst_wready",  32'(s_wready),  32'd0);
    chk("rst_bvalid",  32'(s_bvalid),  32'd0);
    chk("rst_bid",     32'(s_bid),     32'd0);
    chk("rst_bresp",   32'(s_bresp),   32'd0);
    chk("rst_outst",   32'(outstanding), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rel_awready_before_edge", 32'(s_awready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel_awready", 32'(s_awready), 32'd1);
    chk("rel_outst",   32'(outstanding), 32'd0);
    @(posedge clk); #1;

    // Single burst, latency 1 to B
    s_bready = 1'b1;
    b0 = beats;
    sb_q.push_back('{id: 1'b1, resp: 2'b00});
    do_aw(1'b1, 32'h10, 8'd3);
    do_w(4, 4);
    @(negedge clk);
    chk("single_bvalid_lat", 32'(s_bvalid), 32'd1);
    chk("single_outst_held", 32'(outstanding), 32'd1);
    chk("single_beats", 32'(beats - b0), 32'd4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_outst_zero", 32'(outstanding), 32'd0);
    @(posedge clk); #1;

    // Error bursts
    sb_q.push_back('{id: 1'b0, resp: 2'b10});
    do_aw(1'b0, 32'h1000, 8'd0);
    do_w(1, 1);
    sb_q.push_back('{id: 1'b1, resp: 2'b10});
    do_aw(1'b1, 32'h20, 8'd3);
    do_w(2, 2);
    b0 = beats;
    sb_q.push_back('{id: 1'b0, resp: 2'b10});
    do_aw(1'b0, 32'h30, 8'd1);
    do_w(3, 3);
    chk("missing_last_beats", 32'(beats - b0), 32'd3);
    wait_drain();

    // Full queue with backpressure, then in-order drain
    s_bready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{id: 1'(i), resp: 2'b00});
      do_aw(1'(i), 32'h40 + 32'(i * 4), 8'd0);
      do_w(1, 1);
    end
    @(negedge clk);
    chk("full_outst",   32'(outstanding), 32'd4);
    chk("full_awready", 32'(s_awready), 32'd0);
    chk("full_bvalid",  32'(s_bvalid), 32'd1);
    @(posedge clk); #1;
    s_awid = 1'b1; s_awaddr = 32'h80; s_awlen = 8'd0; s_awvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_awready_held", 32'(s_awready), 32'd0);
      @(posedge clk); #1;
    end
    s_awvalid = 1'b0;
    @(negedge clk);
    chk("full_outst_held", 32'(outstanding), 32'd4);
    @(posedge clk); #1;
    s_bready = 1'b1;
    wait_drain();
    @(negedge clk);
    chk("drain_outst", 32'(outstanding), 32'd0);
    @(posedge clk); #1;

    // AW and W presented together on an empty queue
    sb_q.push_back('{id: 1'b1, resp: 2'b00});
    s_awid = 1'b1; s_awaddr = 32'h50; s_awlen = 8'd0; s_awvalid = 1'b1;
    s_wvalid = 1'b1; s_wlast = 1'b1;
    @(negedge clk);
    chk("order_awready", 32'(s_awready), 32'd1);
    chk("order_wready_same", 32'(s_wready), 32'd0);
    @(posedge clk); #1 s_awvalid = 1'b0;
    @(negedge clk);
    chk("order_wready_next", 32'(s_wready), 32'd1);
    @(posedge clk); #1 s_wvalid = 1'b0; s_wlast = 1'b0;
    @(negedge clk);
    chk("order_bvalid", 32'(s_bvalid), 32'd1);
    wait_drain();

    // Reset with two completed bursts pending
    s_bready = 1'b0;
    sb_q.push_back('{id: 1'b0, resp: 2'b00});
    do_aw(1'b0, 32'h60, 8'd0);
    do_w(1, 1);
    sb_q.push_back('{id: 1'b1, resp: 2'b10});
    do_aw(1'b1, 32'h2000, 8'd1);
    do_w(2, 2);
    @(negedge clk);
    chk("midrst_pre_bvalid", 32'(s_bvalid), 32'd1);
    chk("midrst_pre_outst",  32'(outstanding), 32'd2);
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    chk("midrst_bvalid", 32'(s_bvalid), 32'd0);
    chk("midrst_awready", 32'(s_awready), 32'd0);
    chk("midrst_outst", 32'(outstanding), 32'd0);
    sb_q.delete();
    @(posedge clk); #1 reset_n = 1'b1; s_bready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_bvalid", 32'(s_bvalid), 32'd0);
    end
    chk("post_rst_outst", 32'(outstanding), 32'd0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
